// File: rtl/ma_rx_pkg.sv
// Shared types for the MA bootstrap stream receiver: FSM states and the per-task header record.
package ma_rx_pkg;

    typedef enum logic [3:0] {
        H_TEXT,
        H_DATA,
        H_BSS,
        H_ENTRY,
        BIN,
        D_SIZE,
        D_CNT,
        D_MAP,
        D_GRAPH,
        DONE,
        ERR
    } ma_rx_state_t;

    typedef struct packed {
        logic [31:0] text;
        logic [31:0] data;
        logic [31:0] bss;
        logic [31:0] entry;
    } ma_task_hdr_t;

    localparam int HDR_WORDS = 4;

endpackage

// File: rtl/ma_stream_receiver.sv
// PE-side receiver for the MA bootstrap flit stream: headers, task binaries and MA descriptor.
// Optional protocol checking is enabled by defining MA_RX_SANITY_EN.
module ma_stream_receiver
    import ma_rx_pkg::*;
#(
    parameter int  FLIT_SIZE     = 32,
    parameter int  MAX_TASKS     = 16,
    parameter int  MAX_BIN_WORDS = 16384,
    localparam int TW            = $clog2(MAX_TASKS),
    localparam int AW            = $clog2(MAX_BIN_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 credit_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 mem_we_o,
    input  logic                 mem_ready_i,
    output logic [TW-1:0]        mem_task_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [31:0]          mem_data_o,
    output logic                 hdr_valid_o,
    output logic [31:0]          text_size_o,
    output logic [31:0]          data_size_o,
    output logic [31:0]          bss_size_o,
    output logic [31:0]          entry_o,
    output logic                 desc_we_o,
    output logic [7:0]           desc_idx_o,
    output logic [31:0]          desc_data_o,
    output logic [7:0]           task_cnt_o,
    output logic                 done_o,
    output logic                 error_o
);

    ma_rx_state_t  state_q, state_d, after_bin;
    ma_task_hdr_t  hdr_q;
    logic [TW-1:0] task_q, hdr_task_p1;
    logic [31:0]   flit, nwords_q, nwords_next, word_cnt_q;
    logic [32:0]   nw_sum;
    logic [7:0]    cnt_q, cnt_next, desc_idx_q;
    logic          live_q, hdr_vld_p1, accept, in_desc, bad;

    assign flit        = data_i[31:0];
    assign nw_sum      = {1'b0, hdr_q.text} + {1'b0, hdr_q.data};
    assign nwords_next = 32'(nw_sum >> 2);

`ifdef MA_RX_SANITY_EN
    logic [31:0] dsize_q;

    always_comb begin
        bad = 1'b0;
        case (state_q)
            H_TEXT, H_DATA: bad = (flit[1:0] != 2'b00);
            H_ENTRY:        bad = (nwords_next > 32'(MAX_BIN_WORDS));
            D_CNT:          bad = (flit != dsize_q) || (flit == 32'd0) || (flit > 32'(MAX_TASKS));
            D_GRAPH:        bad = (flit != 32'd0);
            default:        bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (accept && state_q == D_SIZE) dsize_q <= flit;
    end

    assign cnt_next = flit[7:0];
    assign error_o  = (state_q == ERR);
`else
    assign bad      = 1'b0;
    assign cnt_next = 8'(flit[TW-1:0]);
    assign error_o  = 1'b0;
`endif

    // live_q holds credit low during reset and for the first cycle after release
    assign credit_o = live_q && (state_q != DONE) && (state_q != ERR) &&
                      ((state_q != BIN) || mem_ready_i);
    assign accept   = rx_i && credit_o;
    assign in_desc  = state_q inside {D_SIZE, D_CNT, D_MAP, D_GRAPH};

    assign mem_we_o    = accept && (state_q == BIN);
    assign mem_addr_o  = word_cnt_q[AW-1:0];
    assign mem_data_o  = mem_we_o ? flit : '0;
    assign mem_task_o  = hdr_vld_p1 ? hdr_task_p1 : task_q;
    assign desc_we_o   = accept && in_desc;
    assign desc_idx_o  = desc_idx_q;
    assign desc_data_o = desc_we_o ? flit : '0;
    assign hdr_valid_o = hdr_vld_p1;
    assign text_size_o = hdr_q.text;
    assign data_size_o = hdr_q.data;
    assign bss_size_o  = hdr_q.bss;
    assign entry_o     = hdr_q.entry;
    assign task_cnt_o  = cnt_q;
    assign done_o      = (state_q == DONE);

    // Task 0 (the mapper) is followed by the descriptor; later tasks chain or finish
    always_comb begin
        if (task_q == '0)
            after_bin = D_SIZE;
        else if ({{(8-TW){1'b0}}, task_q} + 8'd1 >= cnt_q)
            after_bin = DONE;
        else
            after_bin = H_TEXT;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (bad) begin
                state_d = ERR;
            end else begin
                case (state_q)
                    H_TEXT:  state_d = H_DATA;
                    H_DATA:  state_d = H_BSS;
                    H_BSS:   state_d = H_ENTRY;
                    H_ENTRY: state_d = (nwords_next == 32'd0) ? after_bin : BIN;
                    BIN:     if (word_cnt_q == nwords_q - 32'd1) state_d = after_bin;
                    D_SIZE:  state_d = D_CNT;
                    D_CNT:   state_d = D_MAP;
                    D_MAP:   if (desc_idx_q == cnt_q + 8'd2)
                                 state_d = (cnt_q == 8'd0) ? DONE : D_GRAPH;
                    D_GRAPH: if (desc_idx_q == {cnt_q[6:0], 1'b0} + 8'd2)
                                 state_d = (cnt_q == 8'd1) ? DONE : H_TEXT;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= H_TEXT;
            live_q     <= 1'b0;
            task_q     <= '0;
            cnt_q      <= '0;
            desc_idx_q <= '0;
            word_cnt_q <= '0;
            hdr_vld_p1 <= 1'b0;
            hdr_q      <= '0;
        end else begin
            live_q     <= 1'b1;
            state_q    <= state_d;
            hdr_vld_p1 <= accept && (state_q == H_ENTRY) && !bad;
            if (accept) begin
                case (state_q)
                    H_TEXT:  hdr_q.text <= flit;
                    H_DATA:  hdr_q.data <= flit;
                    H_BSS:   hdr_q.bss  <= flit;
                    H_ENTRY: begin
                        hdr_q.entry <= flit;
                        word_cnt_q  <= '0;
                    end
                    BIN:     word_cnt_q <= word_cnt_q + 32'd1;
                    D_CNT:   cnt_q      <= cnt_next;
                    default: ;
                endcase
                if (in_desc) desc_idx_q <= desc_idx_q + 8'd1;
            end
            if (state_q != H_TEXT && state_d == H_TEXT) task_q <= task_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        hdr_task_p1 <= task_q;
        if (accept && state_q == H_ENTRY) nwords_q <= nwords_next;
    end

endmodule

// File: tb/tb_ma_stream_receiver.sv
// Scoreboard bench for ma_stream_receiver: streams are built from a task/descriptor model,
// expectations are queued as flits are issued and a negedge monitor pops and compares them.
module tb_ma_stream_receiver;

    localparam int K_NONE = 0, K_MEM = 1, K_DESC = 2, K_HDR = 3;

    typedef struct {
        logic [31:0] d;
        int          kind;
        int          tsk;
        int          idx;
        logic [31:0] text;
        logic [31:0] dat;
        logic [31:0] bss;
    } flit_t;

    logic        clk_i = 1'b0;
    logic        rst_i, rx_i, mem_ready_i;
    logic [31:0] data_i;
    logic        credit_o, mem_we_o, hdr_valid_o, desc_we_o, done_o, error_o;
    logic [3:0]  mem_task_o;
    logic [13:0] mem_addr_o;
    logic [31:0] mem_data_o, text_size_o, data_size_o, bss_size_o, entry_o, desc_data_o;
    logic [7:0]  desc_idx_o, task_cnt_o;

    flit_t        stim[$];
    logic [49:0]  exp_mem[$];
    logic [39:0]  exp_desc[$];
    logic [131:0] exp_hdr[$];
    int           n_cmp = 0;
    int           n_fail = 0;

    always #5 clk_i = ~clk_i;

    ma_stream_receiver dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .credit_o(credit_o), .data_i(data_i),
        .mem_we_o(mem_we_o), .mem_ready_i(mem_ready_i), .mem_task_o(mem_task_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .hdr_valid_o(hdr_valid_o),
        .text_size_o(text_size_o), .data_size_o(data_size_o), .bss_size_o(bss_size_o),
        .entry_o(entry_o), .desc_we_o(desc_we_o), .desc_idx_o(desc_idx_o),
        .desc_data_o(desc_data_o), .task_cnt_o(task_cnt_o), .done_o(done_o), .error_o(error_o)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic print_summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    // ---------------- reference model: stream + expected responses ----------------
    function automatic void push_flit(input logic [31:0] d, input int kind, input int tsk,
                                      input int idx, input logic [31:0] text,
                                      input logic [31:0] dat, input logic [31:0] bss);
        flit_t f;
        f.d = d; f.kind = kind; f.tsk = tsk; f.idx = idx;
        f.text = text; f.dat = dat; f.bss = bss;
        stim.push_back(f);
    endfunction

    function automatic void add_task(input int t, input int nw);
        int tw;
        logic [31:0] text, dat, bss, entry;
        tw    = $urandom_range(nw, 0);
        text  = 32'(4 * tw);
        dat   = 32'(4 * (nw - tw));
        bss   = $urandom;
        entry = $urandom;
        push_flit(text, K_NONE, t, 0, 0, 0, 0);
        push_flit(dat, K_NONE, t, 0, 0, 0, 0);
        push_flit(bss, K_NONE, t, 0, 0, 0, 0);
        push_flit(entry, K_HDR, t, 0, text, dat, bss);
        for (int i = 0; i < nw; i++) push_flit($urandom, K_MEM, t, i, 0, 0, 0);
    endfunction

    function automatic void add_desc(input int cnt);
        push_flit(32'(cnt), K_DESC, 0, 0, 0, 0, 0);
        push_flit(32'(cnt), K_DESC, 0, 1, 0, 0, 0);
        for (int i = 0; i <= cnt; i++) push_flit($urandom, K_DESC, 0, 2 + i, 0, 0, 0);
        for (int i = 0; i < cnt; i++) push_flit(32'd0, K_DESC, 0, cnt + 3 + i, 0, 0, 0);
    endfunction

    function automatic void gen_stream(input int cnt, input int nw_fixed);
        stim.delete();
        for (int t = 0; t < cnt; t++) begin
            add_task(t, (nw_fixed >= 0) ? nw_fixed : int'($urandom_range(5, 0)));
            if (t == 0) add_desc(cnt);
        end
    endfunction

    function automatic void push_exp(input flit_t f);
        case (f.kind)
            K_MEM:   exp_mem.push_back({4'(f.tsk), 14'(f.idx), f.d});
            K_DESC:  exp_desc.push_back({8'(f.idx), f.d});
            K_HDR:   exp_hdr.push_back({4'(f.tsk), f.text, f.dat, f.bss, f.d});
            default: ;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        if (mem_we_o) begin
            check("mem_we_needs_ready", mem_ready_i, 1'b1);
            if (exp_mem.size() == 0) check("mem_unexpected_we", mem_we_o, 1'b0);
            else check("mem_write", {mem_task_o, mem_addr_o, mem_data_o}, exp_mem.pop_front());
        end
        if (desc_we_o) begin
            if (exp_desc.size() == 0) check("desc_unexpected_we", desc_we_o, 1'b0);
            else check("desc_write", {desc_idx_o, desc_data_o}, exp_desc.pop_front());
        end
        if (hdr_valid_o) begin
            if (exp_hdr.size() == 0) check("hdr_unexpected_pulse", hdr_valid_o, 1'b0);
            else check("hdr_fields", {mem_task_o, text_size_o, data_size_o, bss_size_o, entry_o},
                       exp_hdr.pop_front());
        end
    end

    // ---------------- driver ----------------
    task automatic send_flit(input flit_t f, input bit stall, input bit gap, input bit rr);
        int guard;
        if (gap) begin
            repeat ($urandom_range(3, 0)) begin
                rx_i = 1'b0;
                @(posedge clk_i); #1;
            end
        end
        push_exp(f);
        rx_i   = 1'b1;
        data_i = f.d;
        if (stall) begin
            mem_ready_i = 1'b0;
            repeat (5) begin
                @(negedge clk_i);
                check("stall_credit", credit_o, 1'b0);
                @(posedge clk_i); #1;
            end
            mem_ready_i = 1'b1;
        end
        guard = 0;
        forever begin
            if (rr) mem_ready_i = ($urandom_range(2, 0) != 0);
            @(negedge clk_i);
            if (credit_o) break;
            @(posedge clk_i); #1;
            guard++;
            if (guard > 500) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: credit_o stayed 0, expected a transfer");
                print_summary();
                $finish;
            end
        end
        @(posedge clk_i); #1;
        rx_i = 1'b0;
    endtask

    task automatic run_stream(input bit gap, input bit rr, input int stall_at, input int upto);
        for (int i = 0; i < upto; i++) begin
            if (i == stim.size() - 1) begin
                @(negedge clk_i);
                check("done_before_last", done_o, 1'b0);
                @(posedge clk_i); #1;
            end
            send_flit(stim[i], i == stall_at, gap, rr);
        end
    endtask

    task automatic finish_stream(input int cnt);
        rx_i = 1'b0;
        mem_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("done", done_o, 1'b1);
        check("credit_after_done", credit_o, 1'b0);
        check("error_clean", error_o, 1'b0);
        check("task_cnt", task_cnt_o, 8'(cnt));
        check("sb_empty", exp_mem.size() + exp_desc.size() + exp_hdr.size(), 0);
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        rx_i = 1'b0;
        mem_ready_i = 1'b1;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        print_summary();
        $finish;
    end

    initial begin
        int cnt, pre;
        rst_i = 1'b1; rx_i = 1'b0; data_i = '0; mem_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("rst_credit", credit_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_error", error_o, 1'b0);
        check("rst_task_cnt", task_cnt_o, 8'd0);
        check("rst_hdr", {text_size_o, data_size_o, bss_size_o, entry_o}, 0);
        check("rst_strobes", {mem_we_o, desc_we_o, hdr_valid_o}, 3'b000);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("credit_after_release", credit_o, 1'b1);
        @(posedge clk_i); #1;

        // single mapper task, fixed content
        stim.delete();
        push_flit(32'd8, K_NONE, 0, 0, 0, 0, 0);
        push_flit(32'd4, K_NONE, 0, 0, 0, 0, 0);
        push_flit(32'd0, K_NONE, 0, 0, 0, 0, 0);
        push_flit(32'h100, K_HDR, 0, 0, 32'd8, 32'd4, 32'd0);
        push_flit(32'hA, K_MEM, 0, 0, 0, 0, 0);
        push_flit(32'hB, K_MEM, 0, 1, 0, 0, 0);
        push_flit(32'hC, K_MEM, 0, 2, 0, 0, 0);
        push_flit(32'd1, K_DESC, 0, 0, 0, 0, 0);
        push_flit(32'd1, K_DESC, 0, 1, 0, 0, 0);
        push_flit(32'h0101, K_DESC, 0, 2, 0, 0, 0);
        push_flit(32'h4, K_DESC, 0, 3, 0, 0, 0);
        push_flit(32'd0, K_DESC, 0, 4, 0, 0, 0);
        run_stream(1'b0, 1'b0, -1, stim.size());
        finish_stream(1);
        rx_i = 1'b1;
        repeat (4) begin
            data_i = $urandom;
            @(posedge clk_i); #1;
        end
        rx_i = 1'b0;
        @(negedge clk_i);
        check("done_sticky", done_o, 1'b1);
        @(posedge clk_i); #1;

        // three tasks, two words each
        do_reset();
        gen_stream(3, 2);
        run_stream(1'b0, 1'b0, -1, stim.size());
        finish_stream(3);

        // memory stall in the middle of a binary
        do_reset();
        stim.delete();
        add_task(0, 8);
        add_desc(1);
        run_stream(1'b0, 1'b0, 7, stim.size());
        finish_stream(1);

        // random streams with rx gaps and random memory back-pressure
        for (int r = 0; r < 4; r++) begin
            do_reset();
            cnt = $urandom_range(4, 1);
            gen_stream(cnt, -1);
            run_stream(1'b1, 1'b1, -1, stim.size());
            finish_stream(cnt);
        end

        // reset in the middle of task 1's binary, then a complete new stream
        do_reset();
        gen_stream(3, 4);
        pre = 0;
        foreach (stim[i]) if (stim[i].kind == K_MEM && stim[i].tsk == 1 && stim[i].idx == 2) pre = i;
        run_stream(1'b0, 1'b0, -1, pre);
        repeat (2) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("partial_sb_empty", exp_mem.size() + exp_desc.size() + exp_hdr.size(), 0);
        check("partial_not_done", done_o, 1'b0);
        @(posedge clk_i); #1;
        do_reset();
        @(negedge clk_i);
        check("reset_task_cnt", task_cnt_o, 8'd0);
        @(posedge clk_i); #1;
        gen_stream(2, -1);
        run_stream(1'b1, 1'b0, -1, stim.size());
        finish_stream(2);

`ifdef MA_RX_SANITY_EN
        do_reset();
        stim.delete();
        push_flit(32'd6, K_NONE, 0, 0, 0, 0, 0);
        run_stream(1'b0, 1'b0, -1, stim.size());
        @(negedge clk_i);
        check("err_text_size", error_o, 1'b1);
        check("err_text_credit", credit_o, 1'b0);
        @(posedge clk_i); #1;

        do_reset();
        stim.delete();
        push_flit(32'd8, K_NONE, 0, 0, 0, 0, 0);
        push_flit(32'd0, K_NONE, 0, 0, 0, 0, 0);
        push_flit(32'd0, K_NONE, 0, 0, 0, 0, 0);
        push_flit(32'h40, K_HDR, 0, 0, 32'd8, 32'd0, 32'd0);
        push_flit(32'h11, K_MEM, 0, 0, 0, 0, 0);
        push_flit(32'h22, K_MEM, 0, 1, 0, 0, 0);
        push_flit(32'd2, K_DESC, 0, 0, 0, 0, 0);
        push_flit(32'd3, K_DESC, 0, 1, 0, 0, 0);
        run_stream(1'b0, 1'b0, -1, stim.size());
        @(negedge clk_i);
        check("err_desc_cnt", error_o, 1'b1);
        check("err_desc_credit", credit_o, 1'b0);
        @(posedge clk_i); #1;
`endif

        print_summary();
        $finish;
    end

endmodule
